// File: rtl/axi_lite_mem_pkg.sv
// Shared types, default MMIO map and the address decoder for the AXI4-Lite memory responder.
package axi_lite_mem_pkg;

  // Read channel states.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  // Address regions.
  typedef enum logic [1:0] {
    DEC_RAM      = 2'd0,
    DEC_CONSOLE  = 2'd1,
    DEC_PASS     = 2'd2,
    DEC_UNMAPPED = 2'd3
  } addr_region_e;

  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;
  localparam logic [31:0] DEF_BAD_DATA     = 32'hDEAD_BEEF;

  // RAM takes priority over MMIO so a register placed inside the RAM window is shadowed.
  function automatic addr_region_e decode_addr(input logic [31:0] addr,
                                               input int unsigned mem_words,
                                               input logic [31:0] console_addr,
                                               input logic [31:0] pass_addr);
    logic [32:0]  ram_limit;
    addr_region_e region;
    ram_limit = 33'(mem_words) << 2;
    if ({1'b0, addr} < ram_limit) begin
      region = DEC_RAM;
    end else if (addr == console_addr) begin
      region = DEC_CONSOLE;
    end else if (addr == pass_addr) begin
      region = DEC_PASS;
    end else begin
      region = DEC_UNMAPPED;
    end
    return region;
  endfunction

endpackage

// File: rtl/axi_lite_mem_responder_if.sv
// AXI4-Lite bus without BRESP/RRESP, matching the picorv32_axi memory port.
interface axi_lite_mem_responder_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi_lite_mem_array.sv
// 1W1R synchronous RAM with byte enables; a same-cycle read of the word being written sees old data.
module axi_lite_mem_array #(
  parameter  int unsigned WORDS = 32768,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Byte-enabled write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read port; holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite program/data memory with console and test-pass MMIO for picorv32_axi.
module axi_lite_mem_responder
  import axi_lite_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 32768,
  parameter int unsigned RD_LATENCY   = 1,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC,
  parameter logic [31:0] BAD_DATA     = DEF_BAD_DATA
) (
  input  logic                     clk,
  input  logic                     resetn,
  axi_lite_mem_responder_if.slave  s,
  output logic                     console_valid,
  output logic [7:0]               console_char,
  output logic                     tests_passed
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(RD_LATENCY - 1);

  // Write channel state.
  logic        aw_held_q, aw_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        console_valid_q, console_valid_d;
  logic [7:0]  console_char_q, console_char_d;
  logic        tests_passed_q, tests_passed_d;
  logic        commit_s;
  logic        ram_we_s;
  addr_region_e wr_region_s;

  // Read channel state.
  rd_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_sel_ram_q, rd_sel_ram_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic        sample_s;
  logic [31:0] rd_addr_s;
  logic        ram_re_s;
  logic [31:0] ram_rdata_s;
  addr_region_e rd_region_s;

  logic unused_prot_s;
  assign unused_prot_s = ^{s.awprot, s.arprot};

  // Write path: independent AW/W capture, commit once both are held, B until bready.
  always_comb begin
    aw_held_d       = aw_held_q;
    awaddr_d        = awaddr_q;
    w_held_d        = w_held_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    bvalid_d        = bvalid_q;
    console_valid_d = 1'b0;
    console_char_d  = console_char_q;
    tests_passed_d  = tests_passed_q;
    commit_s        = aw_held_q && w_held_q;
    wr_region_s     = decode_addr(awaddr_q, MEM_WORDS, CONSOLE_ADDR, PASS_ADDR);

    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (wr_region_s)
        DEC_CONSOLE: begin
          console_valid_d = 1'b1;
          console_char_d  = wdata_q[7:0];
        end
        DEC_PASS: begin
          tests_passed_d = tests_passed_q || (wdata_q == PASS_MAGIC);
        end
        default: begin
          console_valid_d = 1'b0;
        end
      endcase
    end else begin
      commit_s = 1'b0;
    end

    if (s.awvalid && awready_q) begin
      aw_held_d = 1'b1;
      awaddr_d  = s.awaddr;
    end else begin
      awaddr_d = awaddr_d;
    end

    if (s.wvalid && wready_q) begin
      w_held_d = 1'b1;
      wdata_d  = s.wdata;
      wstrb_d  = s.wstrb;
    end else begin
      wdata_d = wdata_d;
    end

    if (bvalid_q && s.bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_d;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // RAM is written only on a committed RAM-region write outside reset.
  assign ram_we_s = commit_s && (wr_region_s == DEC_RAM) && resetn;

  // Write path registers; reset drops any half-captured transaction.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held_q       <= 1'b0;
      awaddr_q        <= 32'd0;
      w_held_q        <= 1'b0;
      wdata_q         <= 32'd0;
      wstrb_q         <= 4'd0;
      bvalid_q        <= 1'b0;
      awready_q       <= 1'b0;
      wready_q        <= 1'b0;
      console_valid_q <= 1'b0;
      console_char_q  <= 8'd0;
      tests_passed_q  <= 1'b0;
    end else begin
      aw_held_q       <= aw_held_d;
      awaddr_q        <= awaddr_d;
      w_held_q        <= w_held_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      bvalid_q        <= bvalid_d;
      awready_q       <= awready_d;
      wready_q        <= wready_d;
      console_valid_q <= console_valid_d;
      console_char_q  <= console_char_d;
      tests_passed_q  <= tests_passed_d;
    end
  end

  // In R_IDLE the RAM is addressed straight from the bus so a latency of 1 is possible.
  assign rd_addr_s   = (state_q == R_IDLE) ? s.araddr : araddr_q;
  assign rd_region_s = decode_addr(rd_addr_s, MEM_WORDS, CONSOLE_ADDR, PASS_ADDR);

  // Read FSM next state: accept, count down the latency, sample, hold response until rready.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    araddr_d     = araddr_q;
    rdata_d      = rdata_q;
    rd_sel_ram_d = rd_sel_ram_q;
    sample_s     = 1'b0;

    case (state_q)
      R_IDLE: begin
        if (s.arvalid && arready_q) begin
          araddr_d = s.araddr;
          if (RD_LATENCY <= 1) begin
            sample_s = 1'b1;
            state_d  = R_RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = R_WAIT;
          end
        end else begin
          state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (cnt_q <= 4'd1) begin
          sample_s = 1'b1;
          state_d  = R_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (s.rready) begin
          state_d = R_IDLE;
        end else begin
          state_d = R_RESP;
        end
      end
      default: begin
        state_d = R_IDLE;
      end
    endcase

    if (sample_s) begin
      rd_sel_ram_d = (rd_region_s == DEC_RAM);
      rdata_d      = BAD_DATA;
    end else begin
      rd_sel_ram_d = rd_sel_ram_d;
    end

    ram_re_s  = sample_s && (rd_region_s == DEC_RAM);
    arready_d = (state_d == R_IDLE);
    rvalid_d  = (state_d == R_RESP);
  end

  // Read FSM registers; reset abandons any outstanding read.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= R_IDLE;
      cnt_q        <= 4'd0;
      araddr_q     <= 32'd0;
      rdata_q      <= 32'd0;
      rd_sel_ram_q <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      araddr_q     <= araddr_d;
      rdata_q      <= rdata_d;
      rd_sel_ram_q <= rd_sel_ram_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
    end
  end

  axi_lite_mem_array #(
    .WORDS (MEM_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (awaddr_q[2 +: IDX_W]),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .re    (ram_re_s),
    .raddr (rd_addr_s[2 +: IDX_W]),
    .rdata (ram_rdata_s)
  );

  assign s.awready     = awready_q;
  assign s.wready      = wready_q;
  assign s.bvalid      = bvalid_q;
  assign s.arready     = arready_q;
  assign s.rvalid      = rvalid_q;
  // Both mux inputs are flops; RAM data is shown only for a RAM-region response.
  assign s.rdata       = rd_sel_ram_q ? ram_rdata_s : rdata_q;
  assign console_valid = console_valid_q;
  assign console_char  = console_char_q;
  assign tests_passed  = tests_passed_q;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Randomised self-checking bench: two responders (read latency 4 and 1) share one stimulus stream.
module tb_axi_lite_mem_responder;

  localparam logic [31:0] CONSOLE = 32'h1000_0000;
  localparam logic [31:0] PASSA   = 32'h2000_0000;
  localparam logic [31:0] MAGIC   = 32'd123456789;
  localparam logic [31:0] BAD     = 32'hDEAD_BEEF;
  localparam logic [31:0] RAM_TOP = 32'h0002_0000;
  localparam int          LAT_A   = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_mem_responder_if ifa ();
  axi_lite_mem_responder_if ifb ();

  logic       cv_a, cv_b, tp_a, tp_b;
  logic [7:0] cc_a, cc_b;

  axi_lite_mem_responder #(.MEM_WORDS(32768), .RD_LATENCY(LAT_A)) dut_a (
    .clk(clk), .resetn(resetn), .s(ifa),
    .console_valid(cv_a), .console_char(cc_a), .tests_passed(tp_a));

  axi_lite_mem_responder #(.MEM_WORDS(32768), .RD_LATENCY(1)) dut_b (
    .clk(clk), .resetn(resetn), .s(ifb),
    .console_valid(cv_b), .console_char(cc_b), .tests_passed(tp_b));

  assign ifb.awvalid = ifa.awvalid;
  assign ifb.awaddr  = ifa.awaddr;
  assign ifb.awprot  = ifa.awprot;
  assign ifb.wvalid  = ifa.wvalid;
  assign ifb.wdata   = ifa.wdata;
  assign ifb.wstrb   = ifa.wstrb;
  assign ifb.bready  = ifa.bready;
  assign ifb.arvalid = ifa.arvalid;
  assign ifb.araddr  = ifa.araddr;
  assign ifb.arprot  = ifa.arprot;
  assign ifb.rready  = ifa.rready;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: word-indexed memory plus MMIO side effects.
  logic [31:0] model_mem [int unsigned];
  logic        model_pass = 1'b0;
  logic [7:0]  model_cc   = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_both(input string tag, input logic [31:0] ga, input logic [31:0] gb,
                            input logic [31:0] exp);
    check_eq({tag, "_a"}, ga, exp);
    check_eq({tag, "_b"}, gb, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr < RAM_TOP) return model_mem.exists(addr >> 2) ? model_mem[addr >> 2] : 32'd0;
    return BAD;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] w;
    if (addr < RAM_TOP) begin
      w = model_read(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      model_mem[addr >> 2] = w;
    end else if (addr == CONSOLE) begin
      model_cc = data[7:0];
    end else if (addr == PASSA && data == MAGIC) begin
      model_pass = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_both({tag, "_awready"}, ifa.awready, ifb.awready, 32'd0);
    check_both({tag, "_wready"},  ifa.wready,  ifb.wready,  32'd0);
    check_both({tag, "_arready"}, ifa.arready, ifb.arready, 32'd0);
    check_both({tag, "_bvalid"},  ifa.bvalid,  ifb.bvalid,  32'd0);
    check_both({tag, "_rvalid"},  ifa.rvalid,  ifb.rvalid,  32'd0);
    check_both({tag, "_rdata"},   ifa.rdata,   ifb.rdata,   32'd0);
    check_both({tag, "_cvalid"},  cv_a, cv_b, 32'd0);
    check_both({tag, "_cchar"},   cc_a, cc_b, 32'd0);
    check_both({tag, "_passed"},  tp_a, tp_b, 32'd0);
  endtask

  // AW offered from cycle aw_off, W from w_off; B held for bdelay cycles.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_off, input int w_off, input int bdelay);
    bit aw_done, w_done, aw_fire, w_fire;
    int k;
    aw_done = 1'b0; w_done = 1'b0; k = 0;
    while (!(aw_done && w_done) && k <= 64) begin
      ifa.awvalid = !aw_done && (k >= aw_off);
      ifa.awaddr  = addr;
      ifa.wvalid  = !w_done && (k >= w_off);
      ifa.wdata   = data;
      ifa.wstrb   = strb;
      @(negedge clk);
      check_both("awready", ifa.awready, ifb.awready, {31'd0, !aw_done});
      check_both("wready",  ifa.wready,  ifb.wready,  {31'd0, !w_done});
      check_both("bvalid_early", ifa.bvalid, ifb.bvalid, 32'd0);
      aw_fire = ifa.awvalid && ifa.awready;
      w_fire  = ifa.wvalid && ifa.wready;
      step();
      if (aw_fire) aw_done = 1'b1;
      if (w_fire)  w_done  = 1'b1;
      k++;
    end
    ifa.awvalid = 1'b0;
    ifa.wvalid  = 1'b0;
    check_eq("wr_accept_bound", {31'd0, aw_done && w_done}, 32'd1);
    check_both("bvalid_commit", ifa.bvalid, ifb.bvalid, 32'd0);
    model_write(addr, data, strb);
    step();
    check_both("bvalid", ifa.bvalid, ifb.bvalid, 32'd1);
    check_both("console_valid", cv_a, cv_b, {31'd0, addr == CONSOLE});
    check_both("console_char", cc_a, cc_b, {24'd0, model_cc});
    check_both("tests_passed", tp_a, tp_b, {31'd0, model_pass});
    for (int i = 0; i < bdelay; i++) begin
      step();
      check_both("bvalid_hold", ifa.bvalid, ifb.bvalid, 32'd1);
      check_both("awready_blocked", ifa.awready, ifb.awready, 32'd0);
      check_both("wready_blocked", ifa.wready, ifb.wready, 32'd0);
      check_both("console_pulse", cv_a, cv_b, 32'd0);
    end
    ifa.bready = 1'b1;
    step();
    ifa.bready = 1'b0;
    check_both("bvalid_done", ifa.bvalid, ifb.bvalid, 32'd0);
    check_both("awready_back", ifa.awready, ifb.awready, 32'd1);
    check_both("wready_back", ifa.wready, ifb.wready, 32'd1);
    check_both("console_pulse_end", cv_a, cv_b, 32'd0);
  endtask

  // Single read; rready held low for rdelay cycles after both responses are valid.
  task automatic do_read(input logic [31:0] addr, input int rdelay);
    logic [31:0] exp;
    exp = model_read(addr);
    ifa.arvalid = 1'b1;
    ifa.araddr  = addr;
    @(negedge clk);
    check_both("arready_idle", ifa.arready, ifb.arready, 32'd1);
    step();
    ifa.arvalid = 1'b0;
    for (int k = 1; k <= LAT_A; k++) begin
      check_eq("rvalid_lat_a", {31'd0, ifa.rvalid}, {31'd0, k >= LAT_A});
      check_eq("rvalid_lat_b", {31'd0, ifb.rvalid}, 32'd1);
      check_both("arready_busy", ifa.arready, ifb.arready, 32'd0);
      if (k < LAT_A) step();
    end
    check_both("rdata", ifa.rdata, ifb.rdata, exp);
    for (int i = 0; i < rdelay; i++) begin
      step();
      check_both("rvalid_hold", ifa.rvalid, ifb.rvalid, 32'd1);
      check_both("rdata_hold", ifa.rdata, ifb.rdata, exp);
      check_both("arready_hold", ifa.arready, ifb.arready, 32'd0);
    end
    ifa.rready = 1'b1;
    step();
    ifa.rready = 1'b0;
    check_both("rvalid_done", ifa.rvalid, ifb.rvalid, 32'd0);
    check_both("arready_back", ifa.arready, ifb.arready, 32'd1);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    step();
    step();
    check_reset_outputs("rst");
    resetn = 1'b1;
    model_pass = 1'b0;
    model_cc   = 8'd0;
    check_reset_outputs("rst_release");
    step();
    check_both("ready_after_rst_aw", ifa.awready, ifb.awready, 32'd1);
    check_both("ready_after_rst_ar", ifa.arready, ifb.arready, 32'd1);
  endtask

  logic [31:0] addr_r, data_r, old_w, new_w;
  int          sel;

  initial begin
    ifa.awvalid = 1'b0; ifa.awaddr = 32'd0; ifa.awprot = 3'd0;
    ifa.wvalid  = 1'b0; ifa.wdata  = 32'd0; ifa.wstrb  = 4'd0; ifa.bready = 1'b0;
    ifa.arvalid = 1'b0; ifa.araddr = 32'd0; ifa.arprot = 3'd0; ifa.rready = 1'b0;
    apply_reset();

    for (int i = 0; i < 256; i++) do_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0);

    do_write(32'h100, 32'hA5A5_1234, 4'hF, 0, 0, 0);
    do_read(32'h100, 0);
    do_write(32'h104, 32'h1111_1111, 4'hF, 0, 0, 0);
    do_write(32'h104, 32'h0000_00FF, 4'h1, 3, 0, 0);
    do_read(32'h104, 0);
    check_eq("partial_word_model", model_read(32'h104), 32'h1111_11FF);
    do_read(32'h100, 5);
    do_write(32'h108, 32'h0BAD_F00D, 4'hF, 1, 0, 5);

    do_read(RAM_TOP, 0);
    do_write(RAM_TOP, 32'h5555_AAAA, 4'hF, 0, 2, 1);
    do_read(32'h0, 0);
    do_write(CONSOLE, 32'h0000_0048, 4'hF, 0, 0, 0);
    do_read(CONSOLE, 1);
    do_write(PASSA, 32'd0, 4'hF, 0, 0, 0);
    do_write(PASSA, MAGIC, 4'hF, 2, 0, 0);
    do_read(PASSA, 0);

    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        addr_r = {20'd0, 8'($urandom_range(0, 255)), 2'b00, 2'($urandom_range(0, 3))};
        if (sel == 5) begin
          case ($urandom_range(0, 2))
            0: addr_r = CONSOLE;
            1: addr_r = PASSA;
            default: addr_r = RAM_TOP + 32'($urandom_range(0, 4095) * 4);
          endcase
        end
        data_r = ($urandom_range(0, 7) == 0) ? MAGIC : $urandom;
        do_write(addr_r, data_r, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        addr_r = (sel == 9) ? RAM_TOP + 32'($urandom_range(0, 4095) * 4)
                            : {20'd0, 8'($urandom_range(0, 255)), 4'd0};
        do_read(addr_r, int'($urandom_range(0, 3)));
      end
    end

    // Write commits in the cycle the latency-1 responder samples the same word.
    old_w = model_read(32'h200);
    new_w = ~old_w ^ 32'h1357_9BDF;
    ifa.awvalid = 1'b1; ifa.awaddr = 32'h200;
    ifa.wvalid  = 1'b1; ifa.wdata  = new_w; ifa.wstrb = 4'hF;
    step();
    ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
    ifa.arvalid = 1'b1; ifa.araddr = 32'h200;
    step();
    ifa.arvalid = 1'b0;
    check_eq("collide_rvalid_b", {31'd0, ifb.rvalid}, 32'd1);
    check_eq("collide_old_b", ifb.rdata, old_w);
    check_both("collide_bvalid", ifa.bvalid, ifb.bvalid, 32'd1);
    model_write(32'h200, new_w, 4'hF);
    ifa.bready = 1'b1;
    step();
    ifa.bready = 1'b0;
    step();
    step();
    check_eq("collide_rvalid_a", {31'd0, ifa.rvalid}, 32'd1);
    check_eq("collide_new_a", ifa.rdata, new_w);
    ifa.rready = 1'b1;
    step();
    ifa.rready = 1'b0;
    check_both("collide_rvalid_done", ifa.rvalid, ifb.rvalid, 32'd0);

    // Reset while the latency-4 read is still counting.
    ifa.arvalid = 1'b1; ifa.araddr = 32'h100;
    step();
    ifa.arvalid = 1'b0;
    step();
    check_eq("rst_mid_wait_rvalid", {31'd0, ifa.rvalid}, 32'd0);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      check_both("rst_rvalid_quiet", ifa.rvalid, ifb.rvalid, 32'd0);
      step();
    end
    do_read(32'h100, 0);

    // Reset during the commit cycle must suppress the RAM write.
    old_w = model_read(32'h104);
    ifa.awvalid = 1'b1; ifa.awaddr = 32'h104;
    ifa.wvalid  = 1'b1; ifa.wdata  = 32'hFFFF_0000; ifa.wstrb = 4'hF;
    step();
    ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
    apply_reset();
    check_both("rst_no_bvalid", ifa.bvalid, ifb.bvalid, 32'd0);
    do_read(32'h104, 0);
    check_eq("rst_abort_model", model_read(32'h104), old_w);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_mem_responder.md
Name: axi_lite_mem_responder

Overview:
Synthesizable AXI4-Lite responder for the picorv32_axi memory port. It holds program/data RAM and two MMIO registers: a console byte sink and a test-pass flag. It replaces the behavioural testbench memory, so the same core wrapper runs in simulation, emulation and FPGA bring-up. Write and read channels run independently; no BRESP/RRESP, matching the core's port set.

Parameters:
MEM_WORDS, 32768, RAM depth in 32-bit words (power of two); byte range 0 .. MEM_WORDS*4-1.
RD_LATENCY, 1, cycles from AR accept to RVALID (1..15).
CONSOLE_ADDR, 32'h1000_0000, write-only console byte register.
PASS_ADDR, 32'h2000_0000, write-only test-pass register.
PASS_MAGIC, 32'd123456789, data value that sets tests_passed.
BAD_DATA, 32'hDEAD_BEEF, read data for unmapped addresses.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awaddr  in  32  write address
s_awprot  in  3  ignored
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_araddr  in  32  read address
s_arprot  in  3  ignored
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  32  read data
console_valid  out  1  one-cycle pulse on console write
console_char  out  8  wdata[7:0] of console write
tests_passed  out  1  sticky pass flag

Behaviour:
- Reset: all outputs registered. awready/wready/arready/bvalid/rvalid/console_valid/tests_passed = 0, rdata = 0, console_char = 0. Readies rise the first cycle after resetn=1. RAM contents are not reset.
- Reset mid-transaction: pending AW/W/AR state and outstanding B/R are discarded. No partial RAM write.
- Write path: AW and W are latched independently, in either order or in the same cycle.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Commit cycle: the first cycle both are held. RAM write with per-byte wstrb; MMIO decode uses the full 32-bit address.
  - bvalid rises the cycle after commit and holds until bready. Held flags clear at commit.
  - A second AW/W is not accepted until the B handshake completes.
- Address decode:
  - RAM hit: addr < MEM_WORDS*4. Index = addr[2 +: log2(MEM_WORDS)]; addr[1:0] ignored.
  - CONSOLE_ADDR write: console_valid pulses 1 cycle (the cycle after commit) with console_char.
  - PASS_ADDR write with wdata==PASS_MAGIC: sets tests_passed, cleared only by reset. Other data has no effect.
  - Unmapped writes complete normally (bvalid) and are dropped.
- Read FSM, R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. On arvalid, latch address; go to R_WAIT with counter = RD_LATENCY-1, or straight to R_RESP when RD_LATENCY=1.
  - R_WAIT: decrement counter; at 0, sample RAM (or BAD_DATA when unmapped; MMIO reads also return BAD_DATA) and go to R_RESP.
  - R_RESP: rvalid=1, rdata stable until rready, then R_IDLE with arready=1 the next cycle. Max one outstanding read.
  - Total AR-accept to rvalid = RD_LATENCY cycles.
- Collision: a write commit in the same cycle the read samples the same word returns the OLD data (read-before-write).
- Write and read channels progress concurrently with no mutual stalls.

Decomposition:
- Package axi_lite_mem_pkg: read-state enum (R_IDLE, R_WAIT, R_RESP), default CONSOLE_ADDR/PASS_ADDR/PASS_MAGIC/BAD_DATA constants, an address-decode function returning {RAM, CONSOLE, PASS, UNMAPPED}.
- Sub-module axi_lite_mem_array: 1W1R synchronous RAM with byte enables, read-before-write, no reset.

Test Plan:
- AW+W same cycle, addr 0x100, data 0xA5A5_1234, wstrb 4'hF; then AR 0x100 -> bvalid 1 cycle after commit; rvalid RD_LATENCY cycles after AR accept, rdata 0xA5A5_1234.
- W (0x0000_00FF, wstrb 4'h1) 3 cycles before AW 0x104 over a prior word 0x1111_1111 -> no commit until AW arrives; read back 0x1111_11FF.
- Read 0x100 with rready low 5 cycles -> rvalid and rdata stable all 5 cycles; arready 0 until the cycle after handshake; bready held low -> awready/wready stay 0.
- Read 0x0002_0000 (MEM_WORDS=32768) -> rdata 0xDEAD_BEEF. Write there, then read 0x0 -> RAM word 0 unchanged.
- Write 0x48 to CONSOLE_ADDR -> console_valid one pulse with char 0x48. Write 0 to PASS_ADDR -> tests_passed stays 0. Write 123456789 -> tests_passed 1, sticky across further traffic.
- RD_LATENCY=4, resetn low during R_WAIT -> rvalid never rises; after release arready=1 next cycle and a new read of 0x100 completes correctly.
